// File: rtl/guess_input_controller.sv
// Debounces keyboard_handler key codes into one event per keystroke (held guess
// handshake, duplicate pulse, enter pulse) and owns the guessed-letter mask/count.
module guess_input_controller #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned RELEASE_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pressed,
  input  logic [4:0]  inputLetter,
  input  logic        game_active,
  input  logic        clear_mask,
  input  logic        guess_ack,
  output logic        guess_valid,
  output logic [4:0]  guess_letter,
  output logic        dup_pulse,
  output logic        enter_pulse,
  output logic [25:0] guessed_mask,
  output logic [4:0]  guess_count
);

  localparam logic [4:0]       CODE_ENTER  = 5'd26;
  localparam logic [4:0]       LAST_LETTER = 5'd25;
  localparam logic [4:0]       COUNT_MAX   = 5'd26;
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SETTLE       = 2'd1,
    ST_ISSUE        = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

  function automatic logic letter_seen(input logic [25:0] mask, input logic [4:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 26; i++) begin
      hit = hit | (mask[i] & (code == 5'(i)));
    end
    return hit;
  endfunction

  function automatic logic [25:0] letter_onehot(input logic [4:0] code);
    logic [25:0] oh;
    for (int i = 0; i < 26; i++) begin
      oh[i] = (code == 5'(i));
    end
    return oh;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] value);
    logic [4:0] res;
    if (value < COUNT_MAX) begin
      res = value + 5'd1;
    end else begin
      res = value;
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        code_q, code_d;
  logic              guess_valid_q, guess_valid_d;
  logic [4:0]        guess_letter_q, guess_letter_d;
  logic              dup_q, dup_d;
  logic              enter_q, enter_d;
  logic [25:0]       mask_q, mask_d;
  logic [4:0]        count_q, count_d;

  logic code_stable_s;
  logic settle_done_s;
  logic release_done_s;
  logic code_is_letter_s;
  logic ack_s;

  assign code_stable_s    = (inputLetter == code_q);
  assign settle_done_s    = (cnt_q == SETTLE_LAST);
  assign release_done_s   = (cnt_q == RELEASE_LAST);
  assign code_is_letter_s = (code_q <= LAST_LETTER);
  assign ack_s            = (state_q == ST_ISSUE) && guess_valid_q && guess_ack;

  // Keystroke FSM: settle, classify, hand over the guess, then wait for release.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    code_d         = code_q;
    guess_valid_d  = guess_valid_q;
    guess_letter_d = guess_letter_q;
    dup_d          = 1'b0;
    enter_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (pressed) begin
          code_d  = inputLetter;
          state_d = ST_SETTLE;
        end else begin
          code_d = code_q;
        end
      end
      ST_SETTLE: begin
        if (!pressed) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else if (!code_stable_s) begin
          code_d = inputLetter;
          cnt_d  = CNT_ZERO;
        end else if (settle_done_s) begin
          // Classify cycle: the registered mask is the one consulted for duplicates.
          cnt_d   = CNT_ZERO;
          state_d = ST_WAIT_RELEASE;
          if (code_q == CODE_ENTER) begin
            enter_d = 1'b1;
          end else if (!code_is_letter_s || !game_active) begin
            enter_d = 1'b0;
          end else if (letter_seen(mask_q, code_q)) begin
            dup_d = 1'b1;
          end else begin
            state_d        = ST_ISSUE;
            guess_valid_d  = 1'b1;
            guess_letter_d = code_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ISSUE: begin
        if (ack_s) begin
          guess_valid_d = 1'b0;
          cnt_d         = CNT_ZERO;
          state_d       = ST_WAIT_RELEASE;
        end else begin
          guess_valid_d = 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (pressed) begin
          cnt_d = CNT_ZERO;
        end else if (release_done_s) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        cnt_d         = CNT_ZERO;
        guess_valid_d = 1'b0;
      end
    endcase
  end

  // Guessed-letter mask and count; a clear in the ack cycle wins.
  always_comb begin
    mask_d  = mask_q;
    count_d = count_q;
    if (clear_mask) begin
      mask_d  = 26'd0;
      count_d = 5'd0;
    end else if (ack_s) begin
      mask_d  = mask_q | letter_onehot(guess_letter_q);
      count_d = sat_inc(count_q);
    end else begin
      mask_d  = mask_q;
      count_d = count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= CNT_ZERO;
      code_q         <= 5'd0;
      guess_valid_q  <= 1'b0;
      guess_letter_q <= 5'd0;
      dup_q          <= 1'b0;
      enter_q        <= 1'b0;
      mask_q         <= 26'd0;
      count_q        <= 5'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      code_q         <= code_d;
      guess_valid_q  <= guess_valid_d;
      guess_letter_q <= guess_letter_d;
      dup_q          <= dup_d;
      enter_q        <= enter_d;
      mask_q         <= mask_d;
      count_q        <= count_d;
    end
  end

  assign guess_valid  = guess_valid_q;
  assign guess_letter = guess_letter_q;
  assign dup_pulse    = dup_q;
  assign enter_pulse  = enter_q;
  assign guessed_mask = mask_q;
  assign guess_count  = count_q;

endmodule

// File: tb/tb_guess_input_controller.sv
// Scoreboard bench for guess_input_controller: directed keystrokes plus random
// keystroke episodes, predicted by a run-length reference model.
module tb_guess_input_controller;

  localparam int S = 4;
  localparam int R = 3;
  localparam int K_GUESS = 0;
  localparam int K_ACK   = 1;
  localparam int K_DUP   = 2;
  localparam int K_ENTER = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        pressed;
  logic [4:0]  inputLetter;
  logic        game_active;
  logic        clear_mask;
  logic        guess_ack;
  logic        guess_valid;
  logic [4:0]  guess_letter;
  logic        dup_pulse;
  logic        enter_pulse;
  logic [25:0] guessed_mask;
  logic [4:0]  guess_count;

  guess_input_controller #(
    .SETTLE_CYCLES (S),
    .RELEASE_CYCLES(R),
    .CNT_W         (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pressed     (pressed),
    .inputLetter (inputLetter),
    .game_active (game_active),
    .clear_mask  (clear_mask),
    .guess_ack   (guess_ack),
    .guess_valid (guess_valid),
    .guess_letter(guess_letter),
    .dup_pulse   (dup_pulse),
    .enter_pulse (enter_pulse),
    .guessed_mask(guessed_mask),
    .guess_count (guess_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          kind;
    logic [4:0]  letter;
    logic [25:0] mask;
    int          count;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model: a keystroke is classified once the same code has been
  // pressed for S+1 consecutive cycles while armed; re-arming needs R released cycles.
  bit          m_armed;
  int          m_run;
  logic [4:0]  m_run_code;
  bit          m_pending;
  logic [4:0]  m_letter;
  int          m_low;
  logic [25:0] m_mask;
  int          m_count;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input logic [4:0] letter, input int n);
    exp_t e;
    e.kind   = kind;
    e.letter = letter;
    e.mask   = m_mask;
    e.count  = m_count;
    e.cyc    = n;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_armed    = 1'b1;
    m_run      = 0;
    m_run_code = 5'd0;
    m_pending  = 1'b0;
    m_letter   = 5'd0;
    m_low      = 0;
    m_mask     = 26'd0;
    m_count    = 0;
  endtask

  task automatic model_step(input bit p, input logic [4:0] c, input bit ga,
                            input bit ack, input bit clr, input int n);
    if (m_armed) begin
      if (!p) m_run = 0;
      else if (m_run > 0 && c == m_run_code) m_run++;
      else begin
        m_run      = 1;
        m_run_code = c;
      end
      if (m_run == S + 1) begin
        m_armed = 1'b0;
        m_run   = 0;
        m_low   = 0;
        if (m_run_code == 5'd26) push_exp(K_ENTER, m_run_code, n);
        else if (m_run_code <= 5'd25 && ga) begin
          if (m_mask[m_run_code]) push_exp(K_DUP, m_run_code, n);
          else begin
            m_pending = 1'b1;
            m_letter  = m_run_code;
            push_exp(K_GUESS, m_run_code, n);
          end
        end
      end
    end else if (m_pending) begin
      if (ack) begin
        m_pending        = 1'b0;
        m_low            = 0;
        m_mask[m_letter] = 1'b1;
        if (m_count < 26) m_count++;
        if (clr) begin
          m_mask  = 26'd0;
          m_count = 0;
        end
        push_exp(K_ACK, m_letter, n);
      end
    end else begin
      if (p) m_low = 0;
      else m_low++;
      if (m_low == R) m_armed = 1'b1;
    end
    if (clr) begin
      m_mask  = 26'd0;
      m_count = 0;
    end
  endtask

  task automatic drive(input bit p, input logic [4:0] c, input bit ga,
                       input bit ack, input bit clr);
    pressed     = p;
    inputLetter = c;
    game_active = ga;
    guess_ack   = ack;
    clear_mask  = clr;
    model_step(p, c, ga, ack, clr, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] c, input int n, input bit ga, input bit ack);
    for (int i = 0; i < n; i++) drive(1'b1, c, ga, ack, 1'b0);
  endtask

  task automatic release_key(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic       prev_valid = 1'b0;
  logic [4:0] held_letter = 5'd0;

  task automatic expect_event(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind == K_GUESS) begin
        check("guess_letter", int'(guess_letter), int'(e.letter));
        held_letter = e.letter;
      end
      if (kind == K_ACK) begin
        check("mask_after_ack", int'(guessed_mask), int'(e.mask));
        check("count_after_ack", int'(guess_count), e.count);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (guess_valid && !prev_valid) expect_event(K_GUESS);
      else if (!guess_valid && prev_valid) expect_event(K_ACK);
      else if (guess_valid) check("guess_letter_hold", int'(guess_letter), int'(held_letter));
      if (dup_pulse) expect_event(K_DUP);
      if (enter_pulse) expect_event(K_ENTER);
      if (dup_pulse || enter_pulse)
        check("pulse_exclusive", int'(dup_pulse) + int'(enter_pulse) + int'(guess_valid), 1);
      prev_valid = guess_valid;
    end
  end

  initial begin
    logic [4:0] code;
    logic [4:0] gcode;
    bit         ga;
    int         sel;
    int         hold;

    reset       = 1'b1;
    pressed     = 1'b0;
    inputLetter = 5'd0;
    game_active = 1'b0;
    clear_mask  = 1'b0;
    guess_ack   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(guess_valid), 0);
    check("reset_letter", int'(guess_letter), 0);
    check("reset_dup", int'(dup_pulse), 0);
    check("reset_enter", int'(enter_pulse), 0);
    check("reset_mask", int'(guessed_mask), 0);
    check("reset_count", int'(guess_count), 0);
    reset = 1'b0;
    release_key(2);

    // First guess, acked two cycles after it appears.
    for (int i = 0; i < 10; i++) drive(1'b1, 5'd7, 1'b1, i == 6, 1'b0);
    release_key(4);
    check("first_mask", int'(guessed_mask), int'(26'h80));
    check("first_count", int'(guess_count), 1);

    // Duplicate and Enter.
    press(5'd7, 8, 1'b1, 1'b0);
    release_key(4);
    press(5'd26, 8, 1'b1, 1'b0);
    release_key(4);

    // Long hold gives one guess; a short release does not re-arm.
    press(5'd3, 50, 1'b1, 1'b1);
    release_key(2);
    press(5'd3, 8, 1'b1, 1'b0);
    release_key(4);
    press(5'd3, 8, 1'b1, 1'b0);
    release_key(4);

    // Code change during settle, then an early release.
    press(5'd2, 2, 1'b1, 1'b1);
    press(5'd5, 8, 1'b1, 1'b1);
    release_key(4);
    press(5'd1, 3, 1'b1, 1'b1);
    release_key(4);

    // Clear in the ack cycle, then silent codes.
    for (int i = 0; i < 8; i++) drive(1'b1, 5'd0, 1'b1, i == 6, i == 6);
    release_key(4);
    check("clear_ack_mask", int'(guessed_mask), 0);
    check("clear_ack_count", int'(guess_count), 0);
    press(5'd31, 8, 1'b1, 1'b1);
    release_key(4);
    press(5'd9, 8, 1'b0, 1'b1);
    release_key(4);

    // Every letter once: full mask, count at 26, then one duplicate.
    drive(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    for (int l = 0; l < 26; l++) begin
      press(5'(l), 8, 1'b1, 1'b1);
      release_key(4);
    end
    check("full_mask", int'(guessed_mask), int'(26'h3ffffff));
    check("full_count", int'(guess_count), 26);
    press(5'd4, 8, 1'b1, 1'b1);
    release_key(4);
    check("full_count_after_dup", int'(guess_count), 26);

    // Random keystroke episodes.
    for (int ep = 0; ep < 200; ep++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) code = 5'($urandom_range(0, 7));
      else if (sel == 6) code = 5'd26;
      else if (sel == 7) code = 5'($urandom_range(27, 31));
      else code = 5'($urandom_range(0, 25));
      ga = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) begin
        gcode = 5'((int'(code) + 1 + $urandom_range(0, 3)) % 32);
        hold  = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++)
          drive(1'b1, gcode, ga, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      end
      hold = $urandom_range(1, 12);
      for (int i = 0; i < hold; i++)
        drive(1'b1, code, ga ^ ($urandom_range(0, 9) == 0),
              $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      hold = $urandom_range(0, 6);
      for (int i = 0; i < hold; i++)
        drive(1'b0, code, ga, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end

    // Flush any outstanding guess, clear, and reset in the middle of ISSUE.
    for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    release_key(4);
    drive(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    release_key(1);
    press(5'd11, 6, 1'b1, 1'b0);
    #2;
    pressed = 1'b0;
    reset   = 1'b1;
    #1;
    check("async_reset_valid", int'(guess_valid), 0);
    check("async_reset_mask", int'(guessed_mask), 0);
    check("async_reset_count", int'(guess_count), 0);
    check("queue_empty_at_reset", sb.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    press(5'd11, 8, 1'b1, 1'b1);
    release_key(4);
    check("post_reset_mask", int'(guessed_mask), int'(26'h800));
    check("post_reset_count", int'(guess_count), 1);
    release_key(3);
    check("pending_expectations", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
